serial_subtractor_ctrl: RTL and testbench

//   Bit-serial N-bit subtractor: sequences a single 1-bit full-subtractor cell

---
 rtl/serial_subtractor_ctrl_pkg.sv | 19 +
 rtl/serial_subtractor_ctrl_if.sv | 25 ++
 rtl/serial_subtractor_ctrl_fs_bit_cell.sv | 11 +
 rtl/serial_subtractor_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and the
// counter width helper.
package serial_sub_pkg;

    localparam logic [1:0] ENC_IDLE = 2'b00;
    localparam logic [1:0] ENC_DONE = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = ENC_IDLE,
        SHIFT = 2'b01,
        DONE  = ENC_DONE
    } state_t;

    // Bit-position counter width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_ctrl_if.sv
// Start/done handshake and operand/result bus between the issuing
// controller (master) and the serial subtractor (slave).
interface serial_subtractor_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor_ctrl_fs_bit_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bi, bo = borrow out.
module fs_bit_cell (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor. One full-subtractor cell is walked over
// the operands LSB first with a registered borrow chain; result is ready
// WIDTH cycles after the accepting edge.
// Optional feature macro: SERIAL_SUB_OVF_EN (signed overflow flag).
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one operand bit processed per cycle, busy=1
// DONE  | one-cycle done pulse; start here launches the next op at once
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    serial_subtractor_ctrl_if.slave  bus
);
    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh_a, sh_b, res;
    logic [WIDTH-1:0] diff_q;
    logic             br, bout_q;
    logic             d_bit, bo_bit;
    logic             load, shift_en, finish;

    fs_bit_cell u_cell (
        .a  (sh_a[0]),
        .b  (sh_b[0]),
        .bi (br),
        .d  (d_bit),
        .bo (bo_bit)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and datapath strobes; start is only looked at in IDLE/DONE
    always_comb begin
        state_nx = IDLE;
        load     = 1'b0;
        shift_en = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end else begin
                    state_nx = IDLE;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt == LAST) begin
                    finish   = 1'b1;
                    state_nx = DONE;
                end else begin
                    state_nx = SHIFT;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, bit-serial shifting and borrow chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a <= '0;
            sh_b <= '0;
            res  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            sh_a <= bus.a;
            sh_b <= bus.b;
            br   <= bus.bin;
            cnt  <= '0;
        end else if (shift_en) begin
            sh_a <= sh_a >> 1;
            sh_b <= sh_b >> 1;
            br   <= bo_bit;
            res  <= {d_bit, res[WIDTH-1:1]};
            // Hold at the last position instead of wrapping past WIDTH-1
            if (!finish) cnt <= cnt + 1'b1;
        end
    end

    // Result registers only change on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q <= '0;
            bout_q <= 1'b0;
        end else if (finish) begin
            diff_q <= {d_bit, res[WIDTH-1:1]};
            bout_q <= bo_bit;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q;

    // On the final bit br is the borrow into the MSB; overflow when it
    // differs from the borrow out of the MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      ovf_q <= 1'b0;
        else if (finish) ovf_q <= br ^ bo_bit;
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed plus randomized bench for serial_subtractor_ctrl (WIDTH=8),
// checked against an arithmetic reference model.
module tb_serial_subtractor_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    serial_subtractor_ctrl_if #(.WIDTH(W)) bus ();

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the captured operands
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         output logic [W-1:0] d, output logic bo, output logic ov);
        int r, s;
        r  = int'(a) - int'(b) - int'(bin);
        s  = int'($signed(a)) - int'($signed(b)) - int'(bin);
        d  = W'(r);
        bo = (r < 0);
`ifdef SERIAL_SUB_OVF_EN
        ov = (s > 127) || (s < -128);
`else
        ov = 1'b0;
`endif
    endtask

    // Waits from the accepting edge until done; optionally fires ignored
    // start pulses with junk operands at cycles 2 and 5 of the operation.
    task automatic wait_result(input bit glitch, output int lat, output int bcnt);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.bin   = 1'($urandom);
        bcnt      = int'(bus.busy);
        lat       = 0;
        while (lat < 4 * W) begin
            @(negedge clk);
            lat++;
            if (glitch && (lat == 2 || lat == 5)) begin
                bus.start = 1'b1;
                bus.a     = W'($urandom);
                bus.b     = W'($urandom);
                bus.bin   = 1'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) break;
            bcnt += int'(bus.busy);
        end
    endtask

    // Called at a negedge; drives start and leaves the bench at the done negedge
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bin, input bit glitch, output logic [W-1:0] ed);
        logic eb, eo;
        int   lat, bcnt;
        model(a, b, bin, ed, eb, eo);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        wait_result(glitch, lat, bcnt);
        chk({tag, " latency"}, lat, W);
        chk({tag, " busy_cycles"}, bcnt, W);
        chk({tag, " diff"}, bus.diff, ed);
        chk({tag, " bout"}, bus.bout, eb);
        chk({tag, " ovf"}, bus.ovf, eo);
    endtask

    task automatic after_done(input string tag, input logic [W-1:0] ed);
        @(negedge clk);
        chk({tag, " done_pulse_1cyc"}, bus.done, 1'b0);
        chk({tag, " busy_idle"}, bus.busy, 1'b0);
        chk({tag, " diff_held"}, bus.diff, ed);
    endtask

    initial begin
        logic [W-1:0] ed, ra, rb;
        logic         rbin;
        int           seen;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst busy", bus.busy, 1'b0);
        chk("rst done", bus.done, 1'b0);
        chk("rst diff", bus.diff, 8'h00);
        chk("rst bout", bus.bout, 1'b0);
        chk("rst ovf", bus.ovf, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("5A-3C", 8'h5A, 8'h3C, 1'b0, 1'b0, ed);
        chk("5A-3C diff_lit", bus.diff, 8'h1E);
        after_done("5A-3C", ed);

        do_op("00-01", 8'h00, 8'h01, 1'b0, 1'b0, ed);
        chk("00-01 diff_lit", bus.diff, 8'hFF);
        after_done("00-01", ed);

        do_op("80-01", 8'h80, 8'h01, 1'b0, 1'b0, ed);
        chk("80-01 diff_lit", bus.diff, 8'h7F);
        after_done("80-01", ed);

        // Back-to-back: second start issued in the DONE cycle
        do_op("10-0F-1", 8'h10, 8'h0F, 1'b1, 1'b0, ed);
        chk("10-0F-1 diff_lit", bus.diff, 8'h00);
        do_op("b2b 03-05", 8'h03, 8'h05, 1'b0, 1'b0, ed);
        chk("b2b diff_lit", bus.diff, 8'hFE);
        after_done("b2b", ed);

        // Start pulses while busy must be ignored
        do_op("ignore_start", 8'hC7, 8'h39, 1'b1, 1'b1, ed);
        after_done("ignore_start", ed);

        // Reset at cycle 4 of an operation
        bus.start = 1'b1;
        bus.a     = 8'h22;
        bus.b     = 8'h11;
        bus.bin   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", bus.busy, 1'b0);
        chk("midrst done", bus.done, 1'b0);
        chk("midrst diff", bus.diff, 8'h00);
        chk("midrst bout", bus.bout, 1'b0);
        chk("midrst ovf", bus.ovf, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (2 * W) begin
            @(negedge clk);
            seen += int'(bus.done) + int'(bus.busy);
        end
        chk("midrst no_done", seen, 0);
        do_op("post_rst 22-11", 8'h22, 8'h11, 1'b0, 1'b0, ed);
        after_done("post_rst", ed);

        // Randomized operations, some chained back-to-back
        for (int i = 0; i < 24; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            do_op($sformatf("rand%0d", i), ra, rb, rbin, bit'($urandom_range(1)), ed);
            if ($urandom_range(1) == 0) after_done($sformatf("rand%0d", i), ed);
        end
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
